// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants, FSM encoding and baud helper for the buffered UART transmitter.
package uart_tx_buffered_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push port: valid/ready handshake with an 8-bit payload.
interface uart_tx_buffered_if;
    logic       valid;
    logic       ready;
    logic [7:0] payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is visible combinationally.
module uart_tx_buffered_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never accepts, even on a popping cycle: no bypass path.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

    assign rdata     = mem[rd_ptr_reg[AW-1:0]];
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign occupancy = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed shifter emitting start/8 data/[parity]/stop, LSB first.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          io_mainClk,
    input  logic                          io_asyncReset,
    uart_tx_buffered_if.slave             io_push,
    output logic                          io_txd,
    output logic                          io_busy,
    output logic [$clog2(FIFO_DEPTH):0]   io_occupancy
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic          stop_reg, stop_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic          txd_reg, txd_next;

    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic          bit_done;

    uart_tx_buffered_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (io_mainClk),
        .rst       (io_asyncReset),
        .push      (io_push.valid),
        .pop       (pop),
        .wdata     (io_push.payload),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .occupancy (io_occupancy)
    );

    assign bit_done = (cnt_reg == CW'(CPB - 1));

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            txd_reg    <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            txd_reg    <= txd_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = bit_done ? '0 : cnt_reg + CW'(1);
        bit_next    = bit_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        pop         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_next  = 1'b0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    stop_next  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_reg == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when more bytes wait.
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (pop) begin
            shift_next  = head;
            parity_next = (^head) ^ (PARITY == PARITY_ODD);
        end

        // The line level is registered from the state being entered.
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
            ST_PARITY: txd_next = parity_next;
            default:   txd_next = 1'b1;
        endcase
    end

    assign io_push.ready = ~full;
    assign io_txd        = txd_reg;
    assign io_busy       = (state_reg != ST_IDLE) || (io_occupancy != '0);

endmodule
